tipi_rx_byte_fifo: RTL
======================

// Module: tipi_rx_byte_fifo
// PURPOSE
//  Downstream stage of the 8-bit serial-in/parallel-out shifter on the Pi->TI path.
//  - Captures each byte the shifter latches: one push per le falling edge.
//  - Holds captured bytes in a small FIFO until the TI side reads them.
//  - Decouples Pi latch timing from TI read timing and flags bytes lost to overflow.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, 2..8 (CPLD budget)
//  AW      2   pointer width = log2(DEPTH); count width is AW+1
// PORTS
//  clk        in   1   single clock, shared with the shifter; all logic on posedge
//  reset      in   1   synchronous, active-high
//  byte_in    in   [0:7]  shifter parallel output; bit 0 = MSB
//  byte_le    in   1   same latch-enable signal the shifter receives
//  rd_stb     in   1   TI read strobe; one-cycle pulse pops the head entry
//  rd_data    out  [0:7]  head entry, first-word-fall-through; 8'h00 when empty
//  rd_valid   out  1   FIFO non-empty
//  full       out  1   count == DEPTH
//  count      out  AW+1   entries held
//  overflow   out  1   byte dropped (pulse or sticky, see CONFIGURATION)
//  ovf_clr    in   1   clears sticky overflow; port exists only with TIPI_RX_OVF_STICKY_EN
// BEHAVIOUR
//  Reset values
//  - Pointers 0, count 0, rd_valid 0, full 0, overflow 0, rd_data 8'h00.
//  - le_q is set to 1, so an le already high when reset releases does not push.
//  Push
//  - le_q <= byte_le every cycle. push = le_q & ~byte_le.
//  - On the push cycle byte_in already holds the latched byte; capture it on that posedge.
//  - le held high for N cycles gives exactly one push.
//  - Back-to-back latches (le low for only 1 cycle) give one push each.
//  Pop
//  - pop = rd_stb & rd_valid. The head advances on the posedge.
//  - rd_data shows the next entry in the following cycle.
//  - rd_stb while empty: ignored; no state change, no flag.
//  Latency
//  - A byte pushed at edge k appears on rd_data with rd_valid=1 after edge k.
//  Full
//  - push & ~pop & full: byte dropped, overflow asserted, storage unchanged.
//  - push & pop while full: both happen; count stays DEPTH; nothing dropped.
//  - push & pop while empty: push only (pop is not qualified); count becomes 1.
//  Arithmetic
//  - Pointers are AW bits and wrap naturally (DEPTH-1 -> 0).
//  - count is AW+1 bits; count += push_ok - pop.
//  Reset mid-operation
//  - All entries discarded; any in-flight le high phase is suppressed by le_q=1.
// CONFIGURATION
//  Macro: TIPI_RX_OVF_STICKY_EN
//  - Defined: overflow sets on a drop and holds until ovf_clr=1 or reset.
//    ovf_clr together with a drop in the same cycle leaves overflow = 1 (set wins).
//  - Undefined: overflow is a one-cycle pulse in the cycle after the drop.
//    No ovf_clr port.
// STRUCTURE
//  Shared header tipi_defs.vh (include-guarded)
//  - `TIPI_BYTE_W = 8
//  - `TIPI_RX_DEPTH_DEF = 4
//  - reset-value constant `TIPI_BYTE_ZERO
//  Sub-module tipi_fall_edge
//  - Registered falling-edge detector with a reset-value parameter.
//  - Reused for other Pi strobes.
//  Storage is a DEPTH x 8 register array. No RAM inference.
// TESTING
//  1 Reset, then le pulse with byte_in=8'hA5 -> one cycle later: rd_valid=1, rd_data=8'hA5, count=1.
//  2 Push 8'h01,02,03,04 (DEPTH=4) -> full=1. Push 8'h05 -> overflow=1, count=4.
//    Pop x4 -> reads 01,02,03,04.
//  3 Full FIFO, push 8'hEE and rd_stb in the same cycle -> count stays 4, no overflow.
//    8'hEE comes out last.
//  4 Empty FIFO, rd_stb pulse -> count=0, rd_data=8'h00, no flag.
//    le held high 5 cycles -> exactly one push.
//  5 le high, reset asserted then released while le still high, then le falls
//    -> no push, count=0.
//  6 With TIPI_RX_OVF_STICKY_EN: overflow stays 1 across 10 idle cycles, clears on ovf_clr.
//    Without the macro: overflow is high for exactly 1 cycle.

Source files
------------

// File: rtl/tipi_rx_byte_fifo_pkg.sv
// Package for the Pi->TI receive byte FIFO.
// Provides the byte type (bit 0 = MSB, matching the shifter's [0:7] order)
// and the byte reset constant derived from tipi_defs.vh.
`include "tipi_defs.vh"

package tipi_rx_byte_fifo_pkg;

  localparam int unsigned BYTE_W = `TIPI_BYTE_W;

  typedef logic [0:BYTE_W-1] tipi_byte_t;

  localparam tipi_byte_t BYTE_ZERO = `TIPI_BYTE_ZERO;

endpackage

// File: rtl/tipi_defs.vh
// Shared TIPI definitions: byte width, default RX FIFO depth and the byte
// reset value. Include-guarded so every file in the slice may include it.
`ifndef TIPI_DEFS_VH
`define TIPI_DEFS_VH

`define TIPI_BYTE_W       8
`define TIPI_RX_DEPTH_DEF 4
`define TIPI_BYTE_ZERO    8'h00

`endif

// File: rtl/tipi_fall_edge.sv
// Registered falling-edge detector for Pi-side strobes.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high
//   sig    in  strobe being watched
//   fall   out one-cycle pulse when sig goes 1 -> 0
// Parameter RST_VAL is the value sig_q takes in reset. With RST_VAL = 1 a
// strobe already high at reset release never produces a pulse: the detector
// also stays disarmed until it has seen sig low once, so a high phase that
// straddles reset is swallowed even when it ends after reset is released.
`include "tipi_defs.vh"

module tipi_fall_edge
  import tipi_rx_byte_fifo_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic fall
);

  logic sig_q;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= RST_VAL;
      armed <= 1'b0;
    end else begin
      sig_q <= sig;
      armed <= armed | ~sig;
    end
  end

  assign fall = sig_q & ~sig & armed;

endmodule

// File: rtl/tipi_rx_byte_fifo.sv
// Pi->TI receive byte FIFO, downstream of the 8-bit SIPO shifter.
// Captures one byte per falling edge of the shifter latch enable and holds
// it until the TI side reads it (first-word-fall-through).
// Ports:
//   clk       in   single clock shared with the shifter
//   reset     in   synchronous, active-high
//   byte_in   in   [0:7] shifter parallel output, bit 0 = MSB
//   byte_le   in   shifter latch enable; a falling edge pushes byte_in
//   rd_stb    in   one-cycle pulse pops the head entry
//   ovf_clr   in   clears sticky overflow (only with TIPI_RX_OVF_STICKY_EN)
//   rd_data   out  [0:7] head entry, 8'h00 when empty
//   rd_valid  out  FIFO non-empty
//   full      out  count == DEPTH
//   count     out  [AW:0] entries held
//   overflow  out  a byte was dropped because the FIFO was full
// Configuration macro TIPI_RX_OVF_STICKY_EN:
//   defined   -> overflow is sticky until ovf_clr or reset (set wins)
//   undefined -> overflow is a one-cycle pulse the cycle after a drop
`include "tipi_defs.vh"

module tipi_rx_byte_fifo
  import tipi_rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH = `TIPI_RX_DEPTH_DEF,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:7]    byte_in,
  input  logic          byte_le,
  input  logic          rd_stb,
`ifdef TIPI_RX_OVF_STICKY_EN
  input  logic          ovf_clr,
`endif
  output logic [0:7]    rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  tipi_byte_t    mem_p0 [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf_q;

  logic push;
  logic pop;
  logic push_ok;
  logic drop;

  tipi_fall_edge #(
    .RST_VAL (1'b1)
  ) u_le_fall (
    .clk   (clk),
    .reset (reset),
    .sig   (byte_le),
    .fall  (push)
  );

  assign rd_valid = (cnt != '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign pop      = rd_stb & rd_valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the head is being read.
  assign push_ok  = push & (~full | pop);
  assign drop     = push & full & ~pop;

  // Stage p0: byte capture into storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_p0[wr_ptr] <= byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

`ifdef TIPI_RX_OVF_STICKY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= drop;
    end
  end
`endif

  assign rd_data  = rd_valid ? mem_p0[rd_ptr] : BYTE_ZERO;
  assign count    = cnt;
  assign overflow = ovf_q;

endmodule
